// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the 32x32 integer register file, with a
// pending-write scoreboard used by issue logic to detect RAW/WAW hazards.
module regfile_write_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester A: ALU writeback
  input  logic              a_valid,
  input  logic [4:0]        a_rd,
  input  logic [DATA_W-1:0] a_value,
  output logic              a_ready,
  // requester B: load / multi-cycle writeback
  input  logic              b_valid,
  input  logic [4:0]        b_rd,
  input  logic [DATA_W-1:0] b_value,
  output logic              b_ready,
  // register-file write port
  output logic              reg_write_en,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] rd_value,
  // issue-time destination marking
  input  logic              issue_en,
  input  logic [4:0]        issue_rd,
  // scoreboard query
  input  logic [4:0]        q_rs1,
  input  logic [4:0]        q_rs2,
  input  logic [4:0]        q_rd,
  output logic              hazard,
  output logic [31:0]       busy
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                wen_q, wen_d;
  logic [4:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [31:0]         busy_q, busy_d;

  logic                xfer_a, xfer_b, xfer;
  logic [4:0]          sel_rd;
  logic [DATA_W-1:0]   sel_val;

  // Readies depend only on valids and the pointer, never on payload.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      a_ready = a_valid && (!b_valid || (last_grant_q == GRANT_B));
      b_ready = b_valid && (!a_valid || (last_grant_q == GRANT_A));
    end
  end

  assign xfer_a = a_valid && a_ready;
  assign xfer_b = b_valid && b_ready;
  assign xfer   = xfer_a || xfer_b;

  always_comb begin
    sel_rd  = a_rd;
    sel_val = a_value;
    if (xfer_b) begin
      sel_rd  = b_rd;
      sel_val = b_value;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    rd_d         = rd_q;
    val_d        = val_q;
    busy_d       = busy_q;

    if (xfer) begin
      last_grant_d = xfer_b ? GRANT_B : GRANT_A;
      wen_d        = (sel_rd != 5'd0);
      rd_d         = sel_rd;
      val_d        = sel_val;
      if (sel_rd != 5'd0) begin
        busy_d[sel_rd] = 1'b0;
      end
    end

    // Applied after the clear so a newly issued writer keeps the register pending.
    if (issue_en && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_B;
      wen_q        <= 1'b0;
      rd_q         <= 5'd0;
      val_q        <= '0;
      busy_q       <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      val_q        <= val_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write_en = wen_q;
  assign rd           = rd_q;
  assign rd_value     = val_q;
  assign busy         = busy_q;

  assign hazard = ((q_rs1 != 5'd0) && busy_q[q_rs1]) ||
                  ((q_rs2 != 5'd0) && busy_q[q_rs2]) ||
                  ((q_rd  != 5'd0) && busy_q[q_rd]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts grants,
// the pending bitmap and queued register writes; a monitor checks the write port.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_value, b_value;
  logic        a_ready, b_ready;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        hazard;
  logic [31:0] busy;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_value(a_value), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_value(b_value), .b_ready(b_ready),
    .reg_write_en(reg_write_en), .rd(rd), .rd_value(rd_value),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int unsigned when;
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;
  wr_t exp_q[$];

  // Reference model state
  logic [31:0] m_busy;
  bit          m_last_b;   // 1: requester B was granted most recently
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  bit          last_xa, last_xb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endfunction

  // Write-port monitor: every pulse must match the oldest predicted write, in its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      if (reg_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cmp("write_cycle", cyc, e.when);
          cmp("write_rd", rd, e.rd);
          cmp("write_value", rd_value, e.val);
        end
      end else if (reg_write_en !== 1'b0) begin
        cmp("write_en_known", reg_write_en, 0);
      end
      while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
        e = exp_q.pop_front();
        cmp("missing_write", 0, {27'd0, e.rd});
      end
    end
  end

  // One clock of stimulus with inputs already applied: check combinational
  // outputs and held state at the falling edge, then advance the model.
  task automatic tick();
    logic        ar, br;
    logic [31:0] nb;
    logic [4:0]  rdx;
    logic [31:0] vx;
    @(negedge clk);
    ar = 1'b0;
    br = 1'b0;
    if (!rst) begin
      ar = a_valid && (!b_valid || m_last_b);
      br = b_valid && (!a_valid || !m_last_b);
    end
    cmp("a_ready", a_ready, ar);
    cmp("b_ready", b_ready, br);
    cmp("busy", busy, m_busy);
    cmp("hazard", hazard, m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd]);
    cmp("rd_held", rd, m_rd);
    cmp("rd_value_held", rd_value, m_val);

    nb = m_busy;
    if (ar || br) begin
      rdx = ar ? a_rd : b_rd;
      vx  = ar ? a_value : b_value;
      if (rdx != 5'd0) begin
        exp_q.push_back('{when: cyc + 1, rd: rdx, val: vx});
        nb[rdx] = 1'b0;
      end
      m_rd     = rdx;
      m_val    = vx;
      m_last_b = br;
    end
    if (issue_en && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
    if (rst) begin
      nb       = 32'd0;
      m_last_b = 1'b1;
      m_rd     = 5'd0;
      m_val    = 32'd0;
    end
    last_xa = ar;
    last_xb = br;
    @(posedge clk);
    m_busy = nb;
    #1;
  endtask

  task automatic drop_done();
    if (last_xa) a_valid = 1'b0;
    if (last_xb) b_valid = 1'b0;
  endtask

  task automatic req_a(input logic [4:0] r, input logic [31:0] v);
    a_valid = 1'b1; a_rd = r; a_value = v;
  endtask

  task automatic req_b(input logic [4:0] r, input logic [31:0] v);
    b_valid = 1'b1; b_rd = r; b_value = v;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_rd = 0; a_value = 0;
    b_valid = 0; b_rd = 0; b_value = 0;
    issue_en = 0; issue_rd = 0;
    q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 32'd0; m_last_b = 1'b1; m_rd = 5'd0; m_val = 32'd0;
    mon_en = 1'b1;

    // Reset state, with requests pending that must not be accepted
    cmp("reset_wen", reg_write_en, 0);
    cmp("reset_rd", rd, 0);
    cmp("reset_rd_value", rd_value, 0);
    cmp("reset_busy", busy, 0);
    req_a(5'd1, 32'h1); req_b(5'd2, 32'h2);
    issue_en = 1; issue_rd = 5'd12;
    tick();
    a_valid = 0; b_valid = 0; issue_en = 0;
    rst = 1'b0;

    // Contest straight out of reset: A first, then B
    req_a(5'd5, 32'h11); req_b(5'd6, 32'h22);
    tick(); drop_done();
    tick(); drop_done();
    tick();

    // B alone
    req_b(5'd7, 32'hABCD);
    tick(); drop_done();
    tick(); tick();

    // A to x0: accepted, no write
    req_a(5'd0, 32'hFFFF);
    tick(); drop_done();
    tick();

    // Hazard on x9 set at issue, cleared by writeback
    issue_en = 1; issue_rd = 5'd9;
    tick();
    issue_en = 0; q_rs1 = 5'd9;
    tick();
    req_a(5'd9, 32'h9999);
    tick(); drop_done();
    tick(); tick();
    q_rs1 = 0;

    // Same-cycle set and clear on x3: set wins, write still happens
    issue_en = 1; issue_rd = 5'd3;
    tick();
    req_b(5'd3, 32'h3333); q_rd = 5'd3;
    tick(); drop_done();
    issue_en = 0;
    tick(); tick();
    q_rd = 0;

    // Reset during a pending transfer with x4 pending
    issue_en = 1; issue_rd = 5'd4;
    tick();
    issue_en = 0;
    req_a(5'd4, 32'h4444);
    rst = 1'b1;
    tick(); tick();
    a_valid = 0;
    rst = 1'b0;
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!a_valid && ($urandom_range(2) == 0))
        req_a(($urandom_range(7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      if (!b_valid && ($urandom_range(2) == 0))
        req_b(($urandom_range(7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      issue_en = ($urandom_range(3) == 0);
      issue_rd = 5'($urandom);
      q_rs1 = 5'($urandom); q_rs2 = 5'($urandom); q_rd = 5'($urandom);
      rst = ($urandom_range(199) == 0);
      tick();
      drop_done();
    end

    a_valid = 0; b_valid = 0; issue_en = 0; rst = 0;
    repeat (3) tick();
    cmp("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: a_valid input 1, a_rd input 5, a_value input 32, a_ready output 1  (requester A, ALU writeback).
REQ-004 SHALL have ports: b_valid input 1, b_rd input 5, b_value input 32, b_ready output 1  (requester B, load/multi-cycle writeback).
REQ-005 SHALL have ports: reg_write_en output 1, rd output 5, rd_value output 32  (register-file write port).
REQ-006 SHALL have ports: issue_en input 1, issue_rd input 5  (mark destination pending at issue).
REQ-007 SHALL have ports: q_rs1 input 5, q_rs2 input 5, q_rd input 5, hazard output 1  (scoreboard query).
REQ-008 SHALL have port: busy output 32  (pending-write bitmap, bit n = xn).

Function
REQ-009 SHALL be a single-port write arbiter plus scoreboard for the 32x32 register file; x0 never written, never busy.
REQ-010 SHALL grant at most one requester per cycle; transfer occurs when valid and ready both high at a rising edge.
REQ-011 SHALL drive a_ready/b_ready combinationally from valid inputs and round-robin pointer; ready never high for a requester whose valid is low.
REQ-012 SHALL, single valid requester: grant it. Both valid: grant the requester not granted last (pointer last_grant).
REQ-013 SHALL update last_grant to the granted requester on every transfer; unchanged in idle cycles.
REQ-014 SHALL register the write: transfer in cycle N -> reg_write_en=1, rd, rd_value presented in cycle N+1 only (one-cycle latency, one-cycle pulse).
REQ-015 SHALL, transfer with rd=0: accept (ready high), produce reg_write_en=0 in N+1, no scoreboard change.
REQ-016 SHALL hold reg_write_en=0 and rd/rd_value at last values in cycles with no transfer.
REQ-017 SHALL require requesters to keep valid and payload stable until transfer; arbiter makes no combinational path from payload to ready.
REQ-018 SHALL set busy[issue_rd] at rising edge when issue_en=1 and issue_rd!=0.
REQ-019 SHALL clear busy[rd] at the edge where the granted transfer is accepted (cycle N), rd!=0.
REQ-020 SHALL, same-cycle set and clear on same register: set wins (busy stays 1, newer writer pending).
REQ-021 SHALL compute hazard combinationally = busy[q_rs1] | busy[q_rs2] | busy[q_rd], index 0 contributes 0.
REQ-022 SHALL not forward values; a write in N+1 is visible to register-file reads from N+2 on.
REQ-023 SHALL never write or set busy for a requester/index while rst=1.

Reset
REQ-024 SHALL, while rst=1 at an edge: reg_write_en=0, rd=0, rd_value=0, busy=0, last_grant=B (A wins first contest).
REQ-025 SHALL hold a_ready=b_ready=0 while rst=1; in-flight transfer discarded, no write pulse after reset deasserts.
REQ-026 SHALL accept requests in the first cycle after rst falls.

Verification
REQ-027 SHALL cover: after reset, a_valid=b_valid=1, a_rd=5/a_value=0x11, b_rd=6/b_value=0x22 held -> cycle1 a_ready=1; cycle2 write x5=0x11, b_ready=1; cycle3 write x6=0x22.
REQ-028 SHALL cover: only b_valid with b_rd=7/0xABCD -> b_ready=1 same cycle, reg_write_en=1, rd=7, rd_value=0xABCD next cycle, one cycle only.
REQ-029 SHALL cover: a_valid, a_rd=0, value 0xFFFF -> a_ready=1, reg_write_en stays 0, busy unchanged.
REQ-030 SHALL cover: issue_en rd=9, then q_rs1=9 -> hazard=1; A transfer rd=9 -> busy[9]=0 next cycle, hazard=0.
REQ-031 SHALL cover: busy[3]=1, same cycle issue_rd=3 and B transfer rd=3 -> busy[3]=1 afterwards, write x3 still pulses.
REQ-032 SHALL cover: rst asserted in cycle of a transfer with busy=0x0000_0010 -> next cycle reg_write_en=0, busy=0, readies 0 during reset.
